// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the radix-2 FFT8 output stage.
package fft_pkg;

  localparam int DEF_DATA_WIDTH = 50;
  localparam int HALF_WIDTH     = DEF_DATA_WIDTH / 2;
  localparam int FFT_N          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/fft_bf_r2.sv
// Unity-twiddle radix-2 butterfly on packed complex samples; each half wraps at its own width.
module fft_bf_r2
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic [DATA_WIDTH-1:0] dif_o
);

  localparam int IM_W = DATA_WIDTH / 2;
  localparam int RE_W = DATA_WIDTH - IM_W;

  logic [RE_W-1:0] sum_re_s, dif_re_s;
  logic [IM_W-1:0] sum_im_s, dif_im_s;

  assign sum_re_s = a_i[DATA_WIDTH-1:IM_W] + b_i[DATA_WIDTH-1:IM_W];
  assign dif_re_s = a_i[DATA_WIDTH-1:IM_W] - b_i[DATA_WIDTH-1:IM_W];
  assign sum_im_s = a_i[IM_W-1:0] + b_i[IM_W-1:0];
  assign dif_im_s = a_i[IM_W-1:0] - b_i[IM_W-1:0];

  assign sum_o = {sum_re_s, sum_im_s};
  assign dif_o = {dif_re_s, dif_im_s};

endmodule

// File: rtl/fft8_stage3_out.sv
// Final FFT8 stage: captures a stage-2 frame, runs four time-shared butterflies, then
// streams the eight bins in natural order over a valid/ready interface.
module fft8_stage3_out
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data [0:FFT_N-1],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [2:0]            out_index
);

  state_e                state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [2:0]            idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] inbuf_q  [0:FFT_N-1];
  logic [DATA_WIDTH-1:0] outbuf_q [0:FFT_N-1];

  logic                  capture_s, calc_s;
  logic [2:0]            idx_nxt_s;
  logic [DATA_WIDTH-1:0] bf_sum_s, bf_dif_s;

  assign capture_s = (state_q == ST_IDLE) && in_valid;
  assign calc_s    = (state_q == ST_CALC);
  assign idx_nxt_s = idx_q + 3'd1;

  fft_bf_r2 #(.DATA_WIDTH(DATA_WIDTH)) u_bf (
    .a_i   (inbuf_q[{k_q, 1'b0}]),
    .b_i   (inbuf_q[{k_q, 1'b1}]),
    .sum_o (bf_sum_s),
    .dif_o (bf_dif_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          k_d     = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        k_d = k_q + 2'd1;
        // Bin 0 was written on k=0, so it is already settled for the first beat.
        if (k_q == 2'd3) begin
          state_d     = ST_SEND;
          idx_d       = 3'd0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_data_d  = outbuf_q[0];
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q == 3'd7) begin
            state_d     = ST_IDLE;
            idx_d       = 3'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = {DATA_WIDTH{1'b0}};
          end else begin
            idx_d      = idx_nxt_s;
            out_last_d = (idx_nxt_s == 3'd7);
            out_data_d = outbuf_q[idx_nxt_s];
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        k_d         = 2'd0;
        idx_d       = 3'd0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State, counters, output registers and both sample buffers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < FFT_N; i++) begin
        inbuf_q[i]  <= {DATA_WIDTH{1'b0}};
        outbuf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      if (capture_s) begin
        for (int i = 0; i < FFT_N; i++) begin
          inbuf_q[i] <= in_data[i];
        end
      end
      if (calc_s) begin
        outbuf_q[bitrev3({k_q, 1'b0})] <= bf_sum_s;
        outbuf_q[bitrev3({k_q, 1'b1})] <= bf_dif_s;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_index = idx_q;

endmodule

// File: tb/tb_fft8_stage3_out.sv
// Directed self-checking bench for fft8_stage3_out with hand-computed bin values.
module tb_fft8_stage3_out;

  localparam int DW = 50;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] in_data [0:7];
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [2:0]    out_index;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] frm [0:7];
  logic [DW-1:0] exp_d [0:7];
  logic [DW-1:0] got_data [0:7];
  logic [2:0]    got_idx [0:7];
  logic          got_last [0:7];
  int            got_n;
  int            first_cyc;
  bit            hold_ok;
  bit            timed_out;

  always #5 clk = ~clk;

  fft8_stage3_out #(.DATA_WIDTH(DW)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index)
  );

  function automatic logic [DW-1:0] pk(input int re, input int im);
    logic [24:0] r;
    logic [24:0] m;
    r = re[24:0];
    m = im[24:0];
    return {r, m};
  endfunction

  task automatic clear_vectors();
    for (int i = 0; i < 8; i++) begin
      frm[i]   = '0;
      exp_d[i] = '0;
    end
  endtask

  task automatic send_frame();
    int cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) in_data[i] = frm[i];
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!in_ready && cyc < 50);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Gathers beats until out_last handshakes; optionally stalls out_ready on one index.
  task automatic collect(input int stall_idx, input int stall_n);
    int cyc;
    int stalled;
    bit in_stall;
    bit done;
    logic [DW-1:0] snap_d;
    logic [2:0] snap_i;
    logic snap_l;
    cyc = 0; stalled = 0; in_stall = 0; done = 0;
    got_n = 0; first_cyc = 0; hold_ok = 1; timed_out = 0;
    snap_d = '0; snap_i = '0; snap_l = 1'b0;
    out_ready = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 100) begin
        timed_out = 1;
        done = 1;
      end else if (out_valid) begin
        if (first_cyc == 0) first_cyc = cyc;
        if (in_stall && (out_data !== snap_d || out_index !== snap_i || out_last !== snap_l))
          hold_ok = 0;
        if (int'(out_index) == stall_idx && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
          in_stall = 1;
          snap_d = out_data; snap_i = out_index; snap_l = out_last;
        end else begin
          out_ready = 1'b1;
          in_stall = 0;
          if (got_n < 8) begin
            got_data[got_n] = out_data;
            got_idx[got_n]  = out_index;
            got_last[got_n] = out_last;
          end
          got_n++;
          if (out_last) done = 1;
        end
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) in_data[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: out_valid=%b out_last=%b required 0 0", out_valid, out_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
    checks++;
    if (out_data !== '0 || out_index !== 3'd0) begin
      failures++;
      $display("FAIL reset_data: out_data=%h out_index=%0d required 0 0", out_data, out_index);
    end
  endtask

  task automatic test_pair0();
    clear_vectors();
    frm[0] = pk(5, 3); frm[1] = pk(2, 1);
    exp_d[0] = pk(7, 4); exp_d[4] = pk(3, 2);
    send_frame();
    collect(-1, 0);
    checks++;
    if (timed_out || got_n != 8) begin
      failures++;
      $display("FAIL pair0_count: beats=%0d timeout=%0b required 8 0", got_n, timed_out);
    end
    checks++;
    if (first_cyc != 5) begin
      failures++;
      $display("FAIL pair0_latency: first beat cycle=%0d required 5", first_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_idx[i] !== i[2:0] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL pair0_beat%0d: data=%h idx=%0d last=%b required %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 7));
      end
    end
  endtask

  task automatic test_pair3();
    clear_vectors();
    frm[6] = pk(-4, 10); frm[7] = pk(6, -2);
    exp_d[3] = pk(2, 8); exp_d[7] = pk(-10, 12);
    send_frame();
    collect(-1, 0);
    checks++;
    if (timed_out || got_n != 8) begin
      failures++;
      $display("FAIL pair3_count: beats=%0d timeout=%0b required 8 0", got_n, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_idx[i] !== i[2:0] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL pair3_beat%0d: data=%h idx=%0d last=%b required %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 7));
      end
    end
  endtask

  task automatic test_wrap_stall();
    clear_vectors();
    frm[2] = pk(16777215, 0); frm[3] = pk(1, -16777216);
    exp_d[2] = pk(-16777216, -16777216);
    exp_d[6] = pk(16777214, -16777216);
    send_frame();
    collect(2, 3);
    checks++;
    if (timed_out || got_n != 8) begin
      failures++;
      $display("FAIL stall_count: beats=%0d timeout=%0b required 8 0", got_n, timed_out);
    end
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL stall_hold: outputs changed while out_ready=0, hold_ok=%0b required 1", hold_ok);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_idx[i] !== i[2:0] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL wrap_beat%0d: data=%h idx=%0d last=%b required %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 7));
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    int beats;
    int cyc;
    clear_vectors();
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_data[0] = pk(5, 3); in_data[1] = pk(2, 1);
    for (int i = 2; i < 8; i++) in_data[i] = '0;
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!in_ready && cyc < 50);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) in_data[i] = '0;
    in_data[6] = pk(-4, 10); in_data[7] = pk(6, -2);
    exp_d[3] = pk(2, 8); exp_d[7] = pk(-10, 12);
    busy = 0; beats = 0; cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (in_ready) break;
      busy++;
      if (out_valid && out_ready) beats++;
    end
    checks++;
    if (busy != 12) begin
      failures++;
      $display("FAIL b2b_busy: in_ready low cycles=%0d required 12", busy);
    end
    checks++;
    if (beats != 8) begin
      failures++;
      $display("FAIL b2b_beats1: frame1 beats=%0d required 8", beats);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(-1, 0);
    checks++;
    if (timed_out || got_n != 8 || first_cyc != 5) begin
      failures++;
      $display("FAIL b2b_frame2: beats=%0d first=%0d timeout=%0b required 8 5 0",
               got_n, first_cyc, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_idx[i] !== i[2:0]) begin
        failures++;
        $display("FAIL b2b_beat%0d: data=%h idx=%0d required %h %0d",
                 i, got_data[i], got_idx[i], exp_d[i], i);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int cyc;
    int late;
    clear_vectors();
    frm[0] = pk(5, 3); frm[1] = pk(2, 1);
    send_frame();
    out_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(out_valid && out_index == 3'd3) && cyc < 40);
    checks++;
    if (!(out_valid && out_index == 3'd3)) begin
      failures++;
      $display("FAIL rst_reach_idx3: out_valid=%b out_index=%0d required 1 3", out_valid, out_index);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_send: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    late = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL rst_no_beats: beats after reset=%0d required 0", late);
    end
    clear_vectors();
    frm[6] = pk(-4, 10); frm[7] = pk(6, -2);
    exp_d[3] = pk(2, 8); exp_d[7] = pk(-10, 12);
    send_frame();
    collect(-1, 0);
    checks++;
    if (timed_out || got_n != 8) begin
      failures++;
      $display("FAIL rst_next_count: beats=%0d timeout=%0b required 8 0", got_n, timed_out);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i] || got_idx[i] !== i[2:0] || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL rst_next_beat%0d: data=%h idx=%0d last=%b required %h %0d %b",
                 i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 7));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pair0();
    test_pair3();
    test_wrap_stall();
    test_back_to_back();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft8_stage3_out.md
FFT8_STAGE3_OUT -- requirements
Module: fft8_stage3_out

Interface
REQ-001 Parameter DATA_WIDTH, default 50, width of one packed complex sample: real in [DATA_WIDTH-1:DATA_WIDTH/2], imaginary in [DATA_WIDTH/2-1:0], both signed two's complement.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_data  in  DATA_WIDTH x [0:7]  8-sample frame from stage 2, indices in stage-2 output order.
- in_valid  in  1  frame present on in_data.
- in_ready  out  1  block can accept a frame.
- out_data  out  DATA_WIDTH  one result sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  marks the 8th sample of a frame.
- out_index  out  3  frequency bin of out_data (0..7).

Function
REQ-003 FSM with three states: IDLE, CALC, SEND; in_ready SHALL be 1 only in IDLE.
REQ-004 IDLE: on in_valid=1 at a rising edge, the frame SHALL be captured into an 8-entry input buffer; state -> CALC; k counter cleared to 0.
REQ-005 CALC: one radix-2 butterfly per cycle, k=0..3, on pair (2k, 2k+1): sum = in[2k]+in[2k+1], dif = in[2k]-in[2k+1]; all twiddles = 1, no multiply.
REQ-006 Real and imaginary halves SHALL be added/subtracted independently at DATA_WIDTH/2 bits, wrapping modulo 2^(DATA_WIDTH/2); no saturation, no growth, no scaling.
REQ-007 Sum SHALL be written to output buffer entry bitrev3(2k), dif to bitrev3(2k+1); bitrev3 maps 0,1,2,3,4,5,6,7 -> 0,4,2,6,1,5,3,7; output buffer is thus in natural bin order.
REQ-008 After k=3 is written, state -> SEND with beat index 0; frame captured at edge t SHALL give out_valid=1 in the cycle after edge t+4 (5-cycle latency to first beat).
REQ-009 SEND: out_data = outbuf[idx], out_index = idx, out_valid=1, out_last = (idx==7); idx advances only on out_valid&&out_ready.
REQ-010 While out_ready=0, out_data, out_index, out_last SHALL hold stable.
REQ-011 Handshake on idx=7 -> state IDLE, out_valid=0 next cycle; in_ready=1 that same next cycle.
REQ-012 in_valid asserted outside IDLE SHALL be ignored (no capture); upstream holds its frame until in_ready.
REQ-013 out_valid SHALL be 0 in IDLE and CALC.

Reset
REQ-014 On rst_i=1 at a rising edge: state IDLE, k=0, idx=0, out_valid=0, out_last=0, out_index=0, out_data=0, in_ready=1 in the following cycle; both buffers cleared to 0.
REQ-015 Reset in any state, including mid-CALC or mid-SEND, SHALL discard the frame in progress; no partial output beats after reset.

Structure
REQ-016 Shared package fft_pkg SHALL hold DATA_WIDTH default, HALF_WIDTH=DATA_WIDTH/2, FFT_N=8, the state enum type, and the bitrev3 function.
REQ-017 One sub-module, fft_bf_r2: combinational packed-complex add/subtract per REQ-006, instantiated once and time-shared over k.

Verification
REQ-018 Directed scenarios:
- in[0]=(re 5, im 3), in[1]=(2,1), rest 0 -> beats idx0=(7,4), idx4=(3,2), all others (0,0); out_last only on idx7.
- in[6]=(-4,10), in[7]=(6,-2), rest 0 -> idx3=(2,8), idx7=(-10,12), others (0,0).
- in[2]=(16777215,0), in[3]=(1,-16777216) -> idx2 real wraps to -16777216, imag -16777216; idx6=(16777214, wraps to -16777216).
- out_ready low 3 cycles at idx2 -> out_data/out_index/out_last frozen, exactly 8 beats delivered, no duplicates.
- in_valid held high with two frames -> frame 1 captured, in_ready=0 for 4 CALC + 8 SEND cycles (out_ready=1), frame 2 captured the cycle after frame 1's last beat.
- rst_i pulsed at SEND idx3 -> out_valid=0 next cycle, in_ready=1, no further beats of that frame; next frame processes correctly.
